// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and the default receive FIFO geometry.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

endpackage

// File: rtl/rx_fifo_ram.sv
// Simple dual-port byte RAM: one synchronous write port, one registered read port, no reset.
module rx_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rd_data_q;

    // Read-first: a same-edge write to rd_addr is not visible on this read.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_fifo_module.sv
// Receive byte FIFO between the UART receive controller and its consumer.
// Pointers, occupancy count, flags and the pop handshake live here; storage is rx_fifo_ram.
module rx_fifo_module
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rx_Done_Sig,
    input  logic [BYTE_W-1:0] Rx_Data,
    input  logic              Read_Req,
    input  logic              Clr_Sig,
    output logic [BYTE_W-1:0] Read_Data,
    output logic              Read_Done_Sig,
    output logic              Empty_Sig,
    output logic              Full_Sig,
    output logic [AW:0]       Count,
    output logic              Overflow_Sig
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              data_valid_q, data_valid_d;
    logic              empty, full;
    logic              do_pop, do_write;
    logic [BYTE_W-1:0] ram_rd_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    always_comb begin
        do_pop       = Read_Req && !empty && !Clr_Sig;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
        do_write     = Rx_Done_Sig && (!full || do_pop) && !Clr_Sig;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        data_valid_d = data_valid_q;
        if (Clr_Sig) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                done_d       = 1'b1;
                data_valid_d = 1'b1;
            end
            if (Rx_Done_Sig && !do_write) begin
                ovf_d = 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
        end
    end

    rx_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (do_write),
        .wr_addr (wr_ptr_q),
        .wr_data (Rx_Data),
        .rd_en   (do_pop),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; Read_Data shows zero until the first pop after reset.
    assign Read_Data     = data_valid_q ? ram_rd_data : '0;
    assign Read_Done_Sig = done_q;
    assign Empty_Sig     = empty;
    assign Full_Sig      = full;
    assign Count         = count_q;
    assign Overflow_Sig  = ovf_q;

endmodule

// File: tb/tb_rx_fifo_module.sv
// Self-checking bench for rx_fifo_module: a reference FIFO model feeds an expected-read queue,
// plus a table of hand-computed vectors and directed multi-cycle sequences.
module tb_rx_fifo_module;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Rx_Done_Sig;
    logic [7:0]    Rx_Data;
    logic          Read_Req;
    logic          Clr_Sig;
    logic [7:0]    Read_Data;
    logic          Read_Done_Sig;
    logic          Empty_Sig;
    logic          Full_Sig;
    logic [AW:0]   Count;
    logic          Overflow_Sig;

    rx_fifo_module #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Rx_Done_Sig   (Rx_Done_Sig),
        .Rx_Data       (Rx_Data),
        .Read_Req      (Read_Req),
        .Clr_Sig       (Clr_Sig),
        .Read_Data     (Read_Data),
        .Read_Done_Sig (Read_Done_Sig),
        .Empty_Sig     (Empty_Sig),
        .Full_Sig      (Full_Sig),
        .Count         (Count),
        .Overflow_Sig  (Overflow_Sig)
    );

    always #5 CLK = ~CLK;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mdl_q[$];
    logic       mdl_ovf     = 1'b0;
    logic [7:0] mdl_rd_data = 8'h00;
    int         max_count   = 0;

    typedef struct {
        logic       rx;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        logic       exp_done;
        logic [7:0] exp_data;
        logic [4:0] exp_count;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic scoreboard_check();
        logic exp_done;
        exp_done = (exp_q.size() != 0);
        check("done_pulse", Read_Done_Sig, exp_done);
        if (exp_done) begin
            mdl_rd_data = exp_q.pop_front();
        end
        check("read_data", Read_Data, mdl_rd_data);
        check("count", Count, mdl_q.size());
        check("empty", Empty_Sig, mdl_q.size() == 0);
        check("full", Full_Sig, mdl_q.size() == DEPTH);
        check("overflow", Overflow_Sig, mdl_ovf);
        if (int'(Count) > max_count) max_count = int'(Count);
    endtask

    // Called at a negedge: drives inputs, updates the model, waits one clock, checks at the next negedge.
    task automatic cycle(input logic rx, input logic [7:0] d, input logic rd, input logic clr);
        bit pop, wr;
        Rx_Done_Sig = rx;
        Rx_Data     = d;
        Read_Req    = rd;
        Clr_Sig     = clr;
        pop = rd && (mdl_q.size() > 0) && !clr;
        wr  = rx && ((mdl_q.size() < DEPTH) || pop) && !clr;
        if (clr) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
        end else begin
            if (pop) exp_q.push_back(mdl_q.pop_front());
            if (wr) mdl_q.push_back(d);
            if (rx && !wr) mdl_ovf = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        scoreboard_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        Rx_Done_Sig = 1'b0;
        Rx_Data     = 8'h00;
        Read_Req    = 1'b0;
        Clr_Sig     = 1'b0;
        RST         = 1'b1;
        mdl_q.delete();
        exp_q.delete();
        mdl_ovf     = 1'b0;
        mdl_rd_data = 8'h00;
        #1;
        check("rst_count", Count, 0);
        check("rst_empty", Empty_Sig, 1);
        check("rst_full", Full_Sig, 0);
        check("rst_ovf", Overflow_Sig, 0);
        check("rst_done", Read_Done_Sig, 0);
        check("rst_data", Read_Data, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        // rx, d, rd, clr, exp_done, exp_data, exp_count
        vecs[0] = '{1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5C, 5'd0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5C, 5'd0};
        vecs[3] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h5C, 5'd1};
        vecs[4] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 8'h5C, 5'd2};
        vecs[5] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA1, 5'd2};
        vecs[6] = '{1'b1, 8'hC6, 1'b1, 1'b1, 1'b0, 8'hA1, 5'd0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA1, 5'd0};
        vecs[8] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 8'hA1, 5'd1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB4, 5'd0};

        RST = 1'b1;
        Rx_Done_Sig = 1'b0;
        Rx_Data = 8'h00;
        Read_Req = 1'b0;
        Clr_Sig = 1'b0;
        @(negedge CLK);
        do_reset();

        // Vector table: empty write+pop, empty read ignored, clear overriding write and pop.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].rx, vecs[i].d, vecs[i].rd, vecs[i].clr);
            check($sformatf("vec%0d_done", i), Read_Done_Sig, vecs[i].exp_done);
            check($sformatf("vec%0d_data", i), Read_Data, vecs[i].exp_data);
            check($sformatf("vec%0d_count", i), Count, vecs[i].exp_count);
        end

        // Three spaced writes then four cycles of Read_Req.
        do_reset();
        cycle(1'b1, 8'h11, 1'b0, 1'b0); idle(9);
        cycle(1'b1, 8'h22, 1'b0, 1'b0); idle(9);
        cycle(1'b1, 8'h33, 1'b0, 1'b0); idle(9);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("seq3_last_data", Read_Data, 8'h33);
        check("seq3_empty", Empty_Sig, 1);
        check("seq3_no_4th_pulse", Read_Done_Sig, 0);

        // Fill past full: 17th byte dropped, overflow sticky through the drain.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 15) begin
                check("fill_full", Full_Sig, 1);
                check("fill_count16", Count, 16);
                check("fill_ovf_before", Overflow_Sig, 0);
            end
        end
        check("fill_ovf_set", Overflow_Sig, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_order", Read_Data, 8'(i));
        end
        check("drain_ovf_sticky", Overflow_Sig, 1);

        // Full FIFO with a simultaneous write and pop accepts the byte.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", Overflow_Sig, 0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        check("full_wp_count", Count, 16);
        check("full_wp_ovf", Overflow_Sig, 0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("full_wp_last", Read_Data, 8'hAA);
        check("full_wp_empty", Empty_Sig, 1);

        // Interleaved write/pop pairs across two pointer wraps.
        do_reset();
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_order", Read_Data, 8'h80 + 8'(i));
        end
        check("wrap_max_count_le2", max_count <= 2, 1);

        // Reset in mid-operation with five bytes stored and Read_Req high.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        check("pre_rst_count", Count, 5);
        Read_Req = 1'b1;
        RST      = 1'b1;
        #1;
        check("mid_rst_count", Count, 0);
        check("mid_rst_empty", Empty_Sig, 1);
        check("mid_rst_done", Read_Done_Sig, 0);
        mdl_q.delete();
        exp_q.delete();
        mdl_ovf     = 1'b0;
        mdl_rd_data = 8'h00;
        @(posedge CLK);
        #1;
        check("mid_rst_done_edge", Read_Done_Sig, 0);
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", Read_Data, 8'h77);

        // Random traffic with occasional clears.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("rand_final_empty", Empty_Sig, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
